// File: rtl/seq_alu_unit.sv
// seq_alu_unit: registered ALU with Start/Busy/Done handshake, half/full width and shift-add multiply
module seq_alu_unit #(
   parameter int WIDTH = 16,
   localparam int HW = WIDTH / 2
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [5:0]       FunSel,
   input  logic             WF,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ALUOut,
   output logic [3:0]       FlagsOut
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic {IDLE, MULT} state_t;
   state_t state;
   logic full, full_q, wf_q, c, o, is_mul, last, hi_nz;
   logic [CW-1:0] msb, mmsb, cnt;
   logic [WIDTH-1:0] mask, a, b, r, rm, mp, lo;
   logic [WIDTH:0] sum;
   logic [2*WIDTH-1:0] mc, acc, acc_nxt;
   logic [3:0] alu_flags, mul_flags;

   function automatic logic [WIDTH-1:0] ext(input logic f, input logic [WIDTH-1:0] v);
      return f ? v : {{HW{v[HW-1]}}, v[HW-1:0]};
   endfunction

   assign full = FunSel[4];
   assign mask = full ? '1 : {{HW{1'b0}}, {HW{1'b1}}};
   assign msb = full ? CW'(WIDTH-1) : CW'(HW-1);
   assign a = A & mask;
   assign b = B & mask;
   assign is_mul = FunSel[5] && FunSel[3:0] == 4'd0;

   // single-cycle datapath: operands are pre-masked to the active width, result masked afterwards
   always_comb begin
      r = '0;
      sum = '0;
      c = FlagsOut[2];
      o = FlagsOut[0];
      case (FunSel[3:0])
         4'd0: r = a;
         4'd1: r = b;
         4'd2: r = ~a;
         4'd3: r = ~b;
         4'd4, 4'd5: begin
            sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, FunSel[0] & FlagsOut[2]};
            r = sum[WIDTH-1:0];
            c = full ? sum[WIDTH] : sum[HW];
            o = (a[msb] == b[msb]) && (r[msb] != a[msb]);
         end
         4'd6: begin
            sum = {1'b0, a} + {1'b0, ~b & mask} + {{WIDTH{1'b0}}, 1'b1};
            r = sum[WIDTH-1:0];
            c = full ? sum[WIDTH] : sum[HW];
            o = (a[msb] != b[msb]) && (r[msb] != a[msb]);
         end
         4'd7: r = a & b;
         4'd8: r = a | b;
         4'd9: r = a ^ b;
         4'd10: r = ~(a & b);
         4'd11: begin
            r = a << 1;
            c = a[msb];
         end
         4'd12: begin
            r = a >> 1;
            c = a[0];
         end
         4'd13: begin
            r = (a >> 1) | (WIDTH'(a[msb]) << msb);
            c = a[0];
         end
         4'd14: begin
            r = (a << 1) | WIDTH'(a[msb]);
            c = a[msb];
         end
         default: begin
            r = (a >> 1) | (WIDTH'(a[0]) << msb);
            c = a[0];
         end
      endcase
      rm = r & mask;
      alu_flags = {rm == '0, c, rm[msb], o};
   end

   assign acc_nxt = acc + (mp[0] ? mc : '0);
   assign mmsb = full_q ? CW'(WIDTH-1) : CW'(HW-1);
   assign lo = full_q ? acc_nxt[WIDTH-1:0] : {{HW{1'b0}}, acc_nxt[HW-1:0]};
   assign hi_nz = full_q ? |acc_nxt[2*WIDTH-1:WIDTH] : |acc_nxt[WIDTH-1:HW];
   assign mul_flags = {lo == '0, hi_nz, lo[mmsb], hi_nz};
   assign last = cnt == (full_q ? CW'(WIDTH-2) : CW'(HW-2));

   // control FSM: bit 0 of the multiply is folded into the accept edge so Done lands W cycles later
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         Busy <= 1'b0;
         Done <= 1'b0;
         ALUOut <= '0;
         FlagsOut <= '0;
         cnt <= '0;
         full_q <= 1'b0;
         wf_q <= 1'b0;
         mc <= '0;
         mp <= '0;
         acc <= '0;
      end else begin
         Done <= 1'b0;
         if (state == IDLE) begin
            if (Start && is_mul) begin
               state <= MULT;
               Busy <= 1'b1;
               cnt <= '0;
               full_q <= full;
               wf_q <= WF;
               mc <= {{WIDTH{1'b0}}, a} << 1;
               mp <= b >> 1;
               acc <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            end else if (Start) begin
               Done <= 1'b1;
               ALUOut <= FunSel[5] ? '0 : ext(full, rm);
               if (WF && !FunSel[5]) FlagsOut <= alu_flags;
            end
         end else begin
            acc <= acc_nxt;
            mc <= mc << 1;
            mp <= mp >> 1;
            cnt <= cnt + 1'b1;
            if (last) begin
               state <= IDLE;
               Busy <= 1'b0;
               Done <= 1'b1;
               ALUOut <= ext(full_q, lo);
               if (wf_q) FlagsOut <= mul_flags;
            end
         end
      end
   end
endmodule

// File: tb/tb_seq_alu_unit.sv
// tb_seq_alu_unit: scoreboard bench for seq_alu_unit against an arithmetic reference model
module tb_seq_alu_unit;
   logic Clock = 0, Reset = 1, Start = 0, WF = 0;
   logic [15:0] A = 0, B = 0;
   logic [5:0] FunSel = 0;
   logic Busy, Done;
   logic [15:0] ALUOut;
   logic [3:0] FlagsOut;
   typedef struct {
      logic [15:0] out;
      logic [3:0] fl;
      int lat;
      time t;
   } exp_t;
   exp_t q[$];
   logic [3:0] mfl = 0;
   int checks = 0, errors = 0;

   seq_alu_unit #(.WIDTH(16)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .A(A), .B(B), .FunSel(FunSel), .WF(WF),
      .Busy(Busy), .Done(Done), .ALUOut(ALUOut), .FlagsOut(FlagsOut)
   );

   always #5 Clock = ~Clock;

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endfunction

   // expected {flags, ALUOut} from plain arithmetic on W-bit values
   function automatic logic [19:0] ref_op(input logic [5:0] fs, input logic [15:0] ai, input logic [15:0] bi, input logic wf, input logic [3:0] fl);
      int w;
      longint unsigned m, a, b, r, s, top;
      logic z, c, n, o;
      logic [15:0] out;
      w = fs[4] ? 16 : 8;
      m = (64'd1 << w) - 1;
      top = 64'd1 << (w - 1);
      a = {48'd0, ai} & m;
      b = {48'd0, bi} & m;
      r = 0;
      {z, c, n, o} = fl;
      if (fs[5]) begin
         if (fs[3:0] != 0) return {fl, 16'h0000};
         s = a * b;
         r = s & m;
         c = (s >> w) != 0;
         o = c;
      end else begin
         case (fs[3:0])
            0: r = a;
            1: r = b;
            2: r = ~a & m;
            3: r = ~b & m;
            4, 5: begin
               s = a + b + ((fs[0] && fl[2]) ? 1 : 0);
               r = s & m;
               c = s > m;
               o = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
            end
            6: begin
               r = (a - b) & m;
               c = a >= b;
               o = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
            end
            7: r = a & b;
            8: r = a | b;
            9: r = a ^ b;
            10: r = ~(a & b) & m;
            11: begin r = (a << 1) & m; c = a[w-1]; end
            12: begin r = a >> 1; c = a[0]; end
            13: begin r = (a >> 1) | (a & top); c = a[0]; end
            14: begin r = ((a << 1) | (a >> (w - 1))) & m; c = a[w-1]; end
            default: begin r = (a >> 1) | ((a & 1) << (w - 1)); c = a[0]; end
         endcase
      end
      z = r == 0;
      n = r[w-1];
      out = r[15:0];
      if (w == 8 && n) out[15:8] = 8'hFF;
      return {wf ? {z, c, n, o} : fl, out};
   endfunction

   // monitor: every Done pops one expectation and checks data, flags and latency
   always @(negedge Clock) begin
      exp_t e;
      if (Done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: got Done=1 with nothing outstanding, expected Done=0");
         end else begin
            e = q.pop_front();
            chk("sb_aluout", ALUOut, e.out);
            chk("sb_flags", FlagsOut, e.fl);
            chk("sb_latency", int'(($time - e.t + 5) / 10), e.lat);
            chk("sb_busy_at_done", Busy, 0);
         end
      end
   end

   // issue one op at a negedge; while busy, waves junk Start requests that must be ignored
   task automatic issue(input logic [5:0] fs, input logic [15:0] a, input logic [15:0] b, input logic w);
      exp_t e;
      logic [19:0] res;
      for (int i = 0; i < 100 && Busy; i++) begin
         Start = $urandom_range(2) == 0;
         FunSel = 6'($urandom);
         A = 16'($urandom);
         B = 16'($urandom);
         WF = 1'($urandom);
         @(negedge Clock);
      end
      if (Busy) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout: got Busy=1 after 100 cycles, expected 0");
      end
      FunSel = fs;
      A = a;
      B = b;
      WF = w;
      Start = 1;
      res = ref_op(fs, a, b, w, mfl);
      mfl = res[19:16];
      e.out = res[15:0];
      e.fl = res[19:16];
      e.lat = (fs[5] && fs[3:0] == 0) ? (fs[4] ? 16 : 8) : 1;
      @(posedge Clock);
      e.t = $time;
      q.push_back(e);
      #1 Start = 0;
      @(negedge Clock);
   endtask

   // wait (bounded) for Done, counting Busy cycles; poke injects a mid-op Start
   task automatic wait_done(output int bc, input logic poke);
      bc = 0;
      for (int i = 0; i < 100 && !Done; i++) begin
         if (Busy) bc++;
         if (poke && i == 3) begin
            Start = 1;
            FunSel = 6'b010000;
            A = 16'hBEEF;
         end
         if (poke && i == 4) Start = 0;
         @(negedge Clock);
      end
      Start = 0;
      if (!Done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got Done=0 after 100 cycles, expected 1");
      end
   endtask

   initial begin
      int bc;
      int sel;
      logic [5:0] fs;
      @(negedge Clock);
      chk("rst_aluout", ALUOut, 0);
      chk("rst_flags", FlagsOut, 0);
      chk("rst_done", Done, 0);
      chk("rst_busy", Busy, 0);
      @(negedge Clock);
      Reset = 0;
      @(negedge Clock);
      issue(6'b010100, 16'h7FFF, 16'h0001, 1);
      wait_done(bc, 0);
      chk("add_ovf_out", ALUOut, 16'h8000);
      chk("add_ovf_flags", FlagsOut, 4'b0011);
      issue(6'b000110, 16'h0012, 16'h0034, 1);
      wait_done(bc, 0);
      chk("half_sub_out", ALUOut, 16'hFFDE);
      chk("half_sub_flags", FlagsOut, 4'b0010);
      issue(6'b010100, 16'hFFFF, 16'h0001, 1);
      wait_done(bc, 0);
      chk("add_carry_out", ALUOut, 16'h0000);
      chk("add_carry_flags", FlagsOut, 4'b1100);
      issue(6'b010101, 16'h0001, 16'h0001, 1);
      wait_done(bc, 0);
      chk("b2b_adc_out", ALUOut, 16'h0003);
      chk("b2b_adc_flags", FlagsOut, 4'b0000);
      issue(6'b110000, 16'h0100, 16'h0100, 1);
      wait_done(bc, 1);
      chk("umul_busy_cycles", bc, 15);
      chk("umul_out", ALUOut, 16'h0000);
      chk("umul_flags", FlagsOut, 4'b1101);
      issue(6'b010100, 16'hFFFF, 16'h0001, 1);
      wait_done(bc, 0);
      chk("preset_flags", FlagsOut, 4'b1100);
      issue(6'b110000, 16'h0003, 16'h0005, 0);
      wait_done(bc, 0);
      chk("umul_nowf_busy", bc, 15);
      chk("umul_nowf_out", ALUOut, 16'h000F);
      chk("umul_nowf_flags", FlagsOut, 4'b1100);
      issue(6'b110000, 16'h1234, 16'h5678, 1);
      repeat (4) @(negedge Clock);
      #2 Reset = 1;
      #1;
      chk("abort_aluout", ALUOut, 0);
      chk("abort_flags", FlagsOut, 0);
      chk("abort_done", Done, 0);
      chk("abort_busy", Busy, 0);
      q.delete();
      mfl = 0;
      @(negedge Clock);
      Reset = 0;
      repeat (20) @(negedge Clock);
      issue(6'b010000, 16'h1234, 16'($urandom), 1);
      wait_done(bc, 0);
      chk("pass_a_out", ALUOut, 16'h1234);
      chk("pass_a_flags", FlagsOut, 4'b0000);
      for (int k = 0; k < 250; k++) begin
         sel = $urandom_range(19);
         fs[4] = 1'($urandom);
         fs[3:0] = 4'($urandom);
         fs[5] = sel < 5;
         if (sel < 4) fs[3:0] = 4'd0;
         issue(fs, 16'($urandom), 16'($urandom), $urandom_range(3) != 0);
         if ($urandom_range(2) == 0) wait_done(bc, 0);
      end
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge Clock);
      repeat (3) @(negedge Clock);
      chk("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
